spi_frame_scheduler: RTL and testbench
======================================

Name: spi_frame_scheduler

Overview:
- Upstream/downstream companion of the 16-bit SPI master.
- Buffers outgoing 16-bit frames in a TX FIFO and launches them one at a time on the master's start/busy handshake.
- Enforces a programmable CS-high gap between frames.
- Captures each received word into an RX FIFO for the application logic (display/sensor controllers).

Parameters:
- DEPTH, 8, entries in each of TX FIFO and RX FIFO (power of two, 2..64)
- GAP_CYCLES, 4, system-clock cycles idle between end of one frame and next start (0 allowed)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- tx_data  in  16  frame to transmit
- tx_wr  in  1  push tx_data into TX FIFO
- tx_full  out  1  TX FIFO full
- tx_level  out  $clog2(DEPTH)+1  TX FIFO occupancy
- rx_data  out  16  head of RX FIFO (valid when rx_valid)
- rx_valid  out  1  RX FIFO non-empty
- rx_rd  in  1  pop RX FIFO head
- clr_err  in  1  clears sticky error flags
- tx_overflow  out  1  sticky: push attempted while TX full
- rx_overflow  out  1  sticky: received word dropped, RX full
- idle  out  1  TX FIFO empty and FSM in IDLE
- spi_data_in  out  16  word to SPI master
- spi_start  out  1  one-cycle start pulse to SPI master
- spi_busy  in  1  SPI master busy
- spi_data_out  in  16  SPI master received word

Behaviour:
- Reset (async, any state, mid-frame included): both FIFOs emptied, FSM→IDLE, gap counter 0.
  - Outputs after reset: spi_start=0, spi_data_in=0, tx_full=0, tx_level=0, rx_valid=0, rx_data=0, tx_overflow=0, rx_overflow=0, idle=1.
  - An in-flight SPI frame is abandoned; the master is reset by the same signal.
- TX FIFO: synchronous push on tx_wr when !tx_full; tx_level updates next cycle.
  - Push while full: ignored, tx_overflow←1.
  - Push and FSM pop in the same cycle: both happen, level unchanged.
- RX FIFO: rx_data/rx_valid show the current head (registered/first-word-fall-through).
  - rx_rd while !rx_valid: ignored.
  - Push and pop in the same cycle: both happen.
- FSM states:
  - IDLE: if TX non-empty → LAUNCH. The head is popped into spi_data_in on the transition.
  - LAUNCH: spi_start=1 for exactly this one cycle → WAIT_BUSY.
  - WAIT_BUSY: wait for spi_busy=1 → WAIT_DONE. spi_start stays 0.
  - WAIT_DONE: on the first cycle spi_busy=0, capture spi_data_out into the RX FIFO (if RX full: drop, rx_overflow←1) → GAP. A capture in the same cycle as rx_rd on a full RX FIFO is accepted.
  - GAP: count GAP_CYCLES cycles → IDLE. With GAP_CYCLES=0, go straight to IDLE.
- Latency: tx_wr into an empty idle block → spi_start asserted 2 cycles later.
  - Frame-to-frame start spacing = SPI frame time + GAP_CYCLES + 3 cycles.
- Completion is detected only by spi_busy falling. The master's avail output is not used (it stays high between frames).
- spi_data_in holds its value from LAUNCH until the next pop.
- Exactly one spi_start pulse per popped word. No start is issued while spi_busy=1.
- clr_err clears both sticky flags next cycle. A same-cycle new error wins (flag stays 1).
- idle = (tx_level==0) && state==IDLE.

Test Plan:
- Reset mid-frame (in WAIT_DONE with 3 words queued) → all outputs at reset values, idle=1, no further spi_start.
- Push 0xA55A, GAP_CYCLES=4, master div_factor=2, MISO loopback → exactly one spi_start pulse 2 cycles after tx_wr; rx_valid rises with rx_data=0xA55A; next start no earlier than 4 cycles after busy falls.
- Push 8 words (0x0001..0x0008) back-to-back, then a 9th (0x0009) → tx_full=1 after the 8th, 9th ignored, tx_overflow=1; all 8 frames sent in order 0x0001..0x0008.
- Never assert rx_rd, send 9 frames → RX holds the first 8 words, 9th dropped, rx_overflow=1; clr_err → 0.
- Simultaneous tx_wr and FSM pop at tx_level=8 (write ignored) and at tx_level=3 (level stays 3) → counts and order verified.
- GAP_CYCLES=0 with 2 queued words → second spi_start exactly 2 cycles after spi_busy falls (WAIT_DONE→GAP→IDLE→LAUNCH collapses to IDLE→LAUNCH path).

Source files
------------

// File: rtl/spi_frame_scheduler.sv
// Frame scheduler for a 16-bit SPI master. TX frames are queued and launched one at a time
// on the start/busy handshake with a CS-high gap, and each received word goes into an RX FIFO.
module spi_frame_scheduler #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [15:0]            i_tx_data,
    input  logic                   i_tx_wr,
    output logic                   o_tx_full,
    output logic [$clog2(DEPTH):0] o_tx_level,
    output logic [15:0]            o_rx_data,
    output logic                   o_rx_valid,
    input  logic                   i_rx_rd,
    input  logic                   i_clr_err,
    output logic                   o_tx_overflow,
    output logic                   o_rx_overflow,
    output logic                   o_idle,
    output logic [15:0]            o_spi_data_in,
    output logic                   o_spi_start,
    input  logic                   i_spi_busy,
    input  logic [15:0]            i_spi_data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t r_state, w_state_nxt;

    logic [15:0]   r_tx_mem [DEPTH];
    logic [AW:0]   r_tx_wp, r_tx_rp;
    logic [AW:0]   w_tx_level;
    logic          w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

    logic [15:0]   r_rx_mem [DEPTH];
    logic [AW:0]   r_rx_wp, r_rx_rp;
    logic          w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rx_cap, w_rx_drop;

    logic [GW-1:0] r_gap_cnt;
    logic [15:0]   r_spi_data;
    logic          r_tx_ovf, r_rx_ovf;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_tx_level = r_tx_wp - r_tx_rp;
    assign w_tx_full  = (w_tx_level == FULL_LVL);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_push  = i_tx_wr && !w_tx_full;
    assign w_tx_pop   = (r_state == S_IDLE) && !w_tx_empty;

    assign w_rx_full  = ((r_rx_wp - r_rx_rp) == FULL_LVL);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_pop   = i_rx_rd && !w_rx_empty;
    assign w_rx_cap   = (r_state == S_WAIT_DONE) && !i_spi_busy;
    // A pop in the same cycle frees the slot, so a capture into a full FIFO is still taken.
    assign w_rx_push  = w_rx_cap && (!w_rx_full || w_rx_pop);
    assign w_rx_drop  = w_rx_cap && w_rx_full && !w_rx_pop;

    always_ff @(posedge i_clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= i_tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= i_spi_data_out;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_spi_data <= '0;
            r_tx_ovf   <= 1'b0;
            r_rx_ovf   <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop) begin
                r_tx_rp    <= r_tx_rp + 1'b1;
                r_spi_data <= r_tx_mem[r_tx_rp[AW-1:0]];
            end
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            r_tx_ovf <= (r_tx_ovf && !i_clr_err) || (i_tx_wr && w_tx_full);
            r_rx_ovf <= (r_rx_ovf && !i_clr_err) || w_rx_drop;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (!w_tx_empty) w_state_nxt = S_LAUNCH;
            S_LAUNCH:    w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (i_spi_busy) w_state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!i_spi_busy) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            S_GAP:       if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    assign o_tx_full     = w_tx_full;
    assign o_tx_level    = w_tx_level;
    assign o_rx_valid    = !w_rx_empty;
    assign o_rx_data     = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rp[AW-1:0]];
    assign o_tx_overflow = r_tx_ovf;
    assign o_rx_overflow = r_rx_ovf;
    assign o_idle        = w_tx_empty && (r_state == S_IDLE);
    assign o_spi_data_in = r_spi_data;
    assign o_spi_start   = (r_state == S_LAUNCH);

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Bench for spi_frame_scheduler: two instances (gap 4 and gap 0), each driving a behavioural SPI master
// with MISO looped back, and a start-order scoreboard that runs alongside the directed sequences.
module tb_spi_frame_scheduler;
    localparam int F = 20;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        tx_wr[2], rx_rd[2], clr[2];
    logic [15:0] tx_data[2];
    logic        tx_full[2], rx_valid[2], txo[2], rxo[2], idle[2], sstart[2];
    logic [3:0]  tx_level[2];
    logic [15:0] rx_data[2], sdin[2];
    logic        busy[2];
    logic [15:0] sdout[2], lat[2];
    int          cnt[2];

    spi_frame_scheduler #(.DEPTH(8), .GAP_CYCLES(4)) u_g4 (
        .i_clk(clk), .i_reset(rst), .i_tx_data(tx_data[0]), .i_tx_wr(tx_wr[0]),
        .o_tx_full(tx_full[0]), .o_tx_level(tx_level[0]), .o_rx_data(rx_data[0]),
        .o_rx_valid(rx_valid[0]), .i_rx_rd(rx_rd[0]), .i_clr_err(clr[0]),
        .o_tx_overflow(txo[0]), .o_rx_overflow(rxo[0]), .o_idle(idle[0]),
        .o_spi_data_in(sdin[0]), .o_spi_start(sstart[0]), .i_spi_busy(busy[0]),
        .i_spi_data_out(sdout[0]));

    spi_frame_scheduler #(.DEPTH(8), .GAP_CYCLES(0)) u_g0 (
        .i_clk(clk), .i_reset(rst), .i_tx_data(tx_data[1]), .i_tx_wr(tx_wr[1]),
        .o_tx_full(tx_full[1]), .o_tx_level(tx_level[1]), .o_rx_data(rx_data[1]),
        .o_rx_valid(rx_valid[1]), .i_rx_rd(rx_rd[1]), .i_clr_err(clr[1]),
        .o_tx_overflow(txo[1]), .o_rx_overflow(rxo[1]), .o_idle(idle[1]),
        .o_spi_data_in(sdin[1]), .o_spi_start(sstart[1]), .i_spi_busy(busy[1]),
        .i_spi_data_out(sdout[1]));

    // SPI master: busy for F cycles after start, then returns the sent word.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                busy[g] <= 1'b0; cnt[g] <= 0; lat[g] <= 16'h0; sdout[g] <= 16'h0;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (sstart[g]) begin
                    busy[g] <= 1'b1; cnt[g] <= F; lat[g] <= sdin[g];
                end else if (busy[g]) begin
                    if (cnt[g] == 1) begin
                        busy[g]  <= 1'b0;
                        sdout[g] <= lat[g];
                    end
                    cnt[g] <= cnt[g] - 1;
                end
            end
        end
    end

    typedef struct {
        logic [15:0] d;
        logic        clr;
        logic        acc;
        logic        full;
        logic [3:0]  lvl;
        logic        ovf;
    } vec_t;
    vec_t tbl[10];

    int          total = 0, bad = 0;
    int          nstart[2];
    logic [15:0] q0[$], q1[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic sb_push(input int g, input logic [15:0] d);
        if (g == 0) q0.push_back(d); else q1.push_back(d);
    endtask

    task automatic push(input int g, input logic [15:0] d, input logic acc);
        tx_data[g] = d; tx_wr[g] = 1'b1;
        if (acc) sb_push(g, d);
        @(negedge clk);
        tx_wr[g] = 1'b0;
    endtask

    task automatic rd_chk(input int g, input logic [15:0] exp);
        chk("rx_valid_rd", {15'd0, rx_valid[g]}, 16'd1);
        chk("rx_data_rd", rx_data[g], exp);
        rx_rd[g] = 1'b1;
        @(negedge clk);
        rx_rd[g] = 1'b0;
    endtask

    task automatic wait_start(input int g);
        int n = 0;
        while (!sstart[g] && n < 300) begin @(negedge clk); n++; end
        chk("start_timeout", {15'd0, sstart[g]}, 16'd1);
    endtask

    task automatic wait_fall(input int g);
        int n = 0;
        while (!busy[g] && n < 300) begin @(negedge clk); n++; end
        while (busy[g] && n < 300) begin @(negedge clk); n++; end
        chk("busy_fall_timeout", {15'd0, busy[g]}, 16'd0);
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (!idle[g] && n < 1000) begin @(negedge clk); n++; end
        chk("idle_timeout", {15'd0, idle[g]}, 16'd1);
    endtask

    task automatic start_monitor();
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (!rst && sstart[g]) begin
                    logic [15:0] e;
                    nstart[g]++;
                    chk("start_while_busy", {15'd0, busy[g]}, 16'd0);
                    if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                        total++; bad++;
                        $display("FAIL unexpected_start inst=%0d word=%h", g, sdin[g]);
                    end else begin
                        e = (g == 0) ? q0.pop_front() : q1.pop_front();
                        chk("start_order", sdin[g], e);
                    end
                end
            end
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{16'(i + 1), 1'b0, 1'b1, (i == 7), 4'(i + 1), 1'b0};
        tbl[8] = '{16'h0009, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1};
        tbl[9] = '{16'h000A, 1'b1, 1'b0, 1'b1, 4'd8, 1'b1};

        rst = 1'b1;
        nstart[0] = 0; nstart[1] = 0;
        for (int g = 0; g < 2; g++) begin
            tx_wr[g] = 1'b0; rx_rd[g] = 1'b0; clr[g] = 1'b0; tx_data[g] = 16'h0;
        end
        fork start_monitor(); join_none
        repeat (2) @(negedge clk);
        chk("rst_start", {15'd0, sstart[0]}, 16'd0);
        chk("rst_level", {12'd0, tx_level[0]}, 16'd0);
        chk("rst_idle", {15'd0, idle[0]}, 16'd1);
        chk("rst_rx_valid", {15'd0, rx_valid[0]}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame: start 2 cycles after the write, loopback capture, gap spacing.
        push(0, 16'hA55A, 1'b1);
        chk("lat_c1", {15'd0, sstart[0]}, 16'd0);
        @(negedge clk);
        chk("lat_c2", {15'd0, sstart[0]}, 16'd1);
        @(negedge clk);
        chk("start_one_pulse", {15'd0, sstart[0]}, 16'd0);
        push(0, 16'hB00B, 1'b1);
        wait_fall(0);
        n = 0;
        while (!sstart[0] && n < 50) begin
            @(negedge clk); n++;
            if (n == 1) begin
                chk("rx_valid_rise", {15'd0, rx_valid[0]}, 16'd1);
                chk("rx_data_a55a", rx_data[0], 16'hA55A);
            end
        end
        chk("gap4_spacing", 16'(n), 16'd6);
        wait_idle(0);
        rd_chk(0, 16'hA55A);
        rd_chk(0, 16'hB00B);
        chk("rx_empty_after", {15'd0, rx_valid[0]}, 16'd0);

        // Fill TX while a lead frame is in flight, then overflow; RX overflows on the 9th frame.
        push(0, 16'h00FF, 1'b1);
        wait_start(0);
        for (int i = 0; i < 10; i++) begin
            tx_data[0] = tbl[i].d; tx_wr[0] = 1'b1; clr[0] = tbl[i].clr;
            if (tbl[i].acc) sb_push(0, tbl[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d_full", i), {15'd0, tx_full[0]}, {15'd0, tbl[i].full});
            chk($sformatf("tbl%0d_level", i), {12'd0, tx_level[0]}, {12'd0, tbl[i].lvl});
            chk($sformatf("tbl%0d_ovf", i), {15'd0, txo[0]}, {15'd0, tbl[i].ovf});
        end
        tx_wr[0] = 1'b0; clr[0] = 1'b0;
        wait_idle(0);
        chk("sent_count9", 16'(nstart[0]), 16'd11);
        chk("rx_ovf_set", {15'd0, rxo[0]}, 16'd1);
        chk("tx_ovf_sticky", {15'd0, txo[0]}, 16'd1);
        rd_chk(0, 16'h00FF);
        for (int i = 1; i <= 7; i++) rd_chk(0, 16'(i));
        chk("rx_drained", {15'd0, rx_valid[0]}, 16'd0);
        rx_rd[0] = 1'b1; @(negedge clk); rx_rd[0] = 1'b0;
        chk("rd_empty_ignored", {15'd0, rx_valid[0]}, 16'd0);
        clr[0] = 1'b1; @(negedge clk); clr[0] = 1'b0;
        chk("clr_tx_ovf", {15'd0, txo[0]}, 16'd0);
        chk("clr_rx_ovf", {15'd0, rxo[0]}, 16'd0);

        // Write coinciding with the FSM pop at level 3: level unchanged.
        push(0, 16'h1000, 1'b1);
        wait_start(0);
        for (int i = 1; i <= 3; i++) push(0, 16'(16'h1000 + i), 1'b1);
        chk("lvl3_before", {12'd0, tx_level[0]}, 16'd3);
        wait_fall(0);
        repeat (5) @(negedge clk);
        push(0, 16'h1004, 1'b1);
        chk("lvl3_collide", {12'd0, tx_level[0]}, 16'd3);
        chk("lvl3_launch", {15'd0, sstart[0]}, 16'd1);
        wait_idle(0);
        for (int i = 0; i <= 4; i++) rd_chk(0, 16'(16'h1000 + i));

        // Write coinciding with the pop at level 8: write dropped, overflow flagged.
        push(0, 16'h2000, 1'b1);
        wait_start(0);
        for (int i = 1; i <= 8; i++) push(0, 16'(16'h2000 + i), 1'b1);
        chk("lvl8_full", {15'd0, tx_full[0]}, 16'd1);
        wait_fall(0);
        repeat (5) @(negedge clk);
        push(0, 16'h2009, 1'b0);
        chk("lvl8_collide", {12'd0, tx_level[0]}, 16'd7);
        chk("lvl8_ovf", {15'd0, txo[0]}, 16'd1);
        wait_idle(0);
        chk("lvl8_rx_ovf", {15'd0, rxo[0]}, 16'd1);

        // Reset mid-frame with 3 words queued.
        push(0, 16'h4000, 1'b1);
        wait_start(0);
        for (int i = 1; i <= 3; i++) push(0, 16'(16'h4000 + i), 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_start", {15'd0, sstart[0]}, 16'd0);
        chk("mrst_sdin", sdin[0], 16'h0000);
        chk("mrst_full", {15'd0, tx_full[0]}, 16'd0);
        chk("mrst_level", {12'd0, tx_level[0]}, 16'd0);
        chk("mrst_rx_valid", {15'd0, rx_valid[0]}, 16'd0);
        chk("mrst_rx_data", rx_data[0], 16'h0000);
        chk("mrst_txo", {15'd0, txo[0]}, 16'd0);
        chk("mrst_rxo", {15'd0, rxo[0]}, 16'd0);
        chk("mrst_idle", {15'd0, idle[0]}, 16'd1);
        q0.delete();
        n = nstart[0];
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("mrst_no_start", 16'(nstart[0] - n), 16'd0);

        // Zero gap: second start exactly 2 cycles after busy falls.
        push(1, 16'h3001, 1'b1);
        push(1, 16'h3002, 1'b1);
        wait_start(1);
        wait_fall(1);
        n = 0;
        while (!sstart[1] && n < 20) begin @(negedge clk); n++; end
        chk("gap0_spacing", 16'(n), 16'd2);
        wait_idle(1);
        rd_chk(1, 16'h3001);
        rd_chk(1, 16'h3002);
        chk("gap0_count", 16'(nstart[1]), 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
